// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 16-bit ALU results in a small FIFO and streams each
// word out of an 8N1 UART line, high byte first, one idle cycle between words.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        external_clk,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [15:0] ALU_result,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [3:0]  ledState
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [3:0] state_onehot(input logic [1:0] st);
        case (st)
            ST_IDLE:  return 4'b0001;
            ST_START: return 4'b0010;
            ST_DATA:  return 4'b0100;
            ST_STOP:  return 4'b1000;
            default:  return 4'b0001;
        endcase
    endfunction

    function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [15:0] mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic        empty_s, full_s, push_s, pop_s;
    logic [15:0] head_s;

    logic [1:0]  state_r, state_s;
    logic [15:0] baud_r, baud_s;
    logic [2:0]  bit_r, bit_s;
    logic [7:0]  shift_r, shift_s;
    logic [7:0]  lo_byte_r, lo_byte_s;
    logic        hi_sel_r, hi_sel_s;
    logic        baud_done_s;

    logic        tx_r, tx_s;
    logic        busy_r, fifo_full_r, overflow_r;
    logic [3:0]  led_r;

    // FIFO occupancy: a pop only ever sees words that were present before the edge.
    always_comb begin
        empty_s  = (wr_ptr_r == rd_ptr_r);
        full_s   = ptr_full(wr_ptr_r, rd_ptr_r);
        push_s   = result_valid & ~full_s;
        pop_s    = (state_r == ST_IDLE) & ~empty_s;
        head_s   = mem_r[rd_ptr_r[AW-1:0]];
        wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    end

    // Serial frame sequencer; the word is latched at pop so later inputs cannot disturb it.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_s       = bit_r;
        shift_s     = shift_r;
        lo_byte_s   = lo_byte_r;
        hi_sel_s    = hi_sel_r;
        tx_s        = tx_r;
        baud_done_s = (baud_r == BAUD_LAST);
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    shift_s   = head_s[15:8];
                    lo_byte_s = head_s[7:0];
                    hi_sel_s  = 1'b1;
                    baud_s    = 16'd0;
                    bit_s     = 3'd0;
                    tx_s      = 1'b0;
                    state_s   = ST_START;
                end else begin
                    tx_s      = 1'b1;
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_s  = 16'd0;
                    tx_s    = shift_r[0];
                    shift_s = {1'b0, shift_r[7:1]};
                    state_s = ST_DATA;
                end else begin
                    baud_s  = baud_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_s = 16'd0;
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        tx_s    = shift_r[0];
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_s = 16'd0;
                    if (hi_sel_r) begin
                        hi_sel_s = 1'b0;
                        shift_s  = lo_byte_r;
                        tx_s     = 1'b0;
                        state_s  = ST_START;
                    end else begin
                        tx_s     = 1'b1;
                        state_s  = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            default: begin
                baud_s  = 16'd0;
                bit_s   = 3'd0;
                tx_s    = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO storage.
    always_ff @(posedge external_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= ALU_result;
        end
    end

    // State, counters and registered status outputs (derived from next-state values).
    always_ff @(posedge external_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            state_r     <= ST_IDLE;
            baud_r      <= 16'd0;
            bit_r       <= 3'd0;
            shift_r     <= 8'h00;
            lo_byte_r   <= 8'h00;
            hi_sel_r    <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            fifo_full_r <= 1'b0;
            overflow_r  <= 1'b0;
            led_r       <= 4'b0001;
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            state_r     <= state_s;
            baud_r      <= baud_s;
            bit_r       <= bit_s;
            shift_r     <= shift_s;
            lo_byte_r   <= lo_byte_s;
            hi_sel_r    <= hi_sel_s;
            tx_r        <= tx_s;
            busy_r      <= (state_s != ST_IDLE) || (wr_ptr_s != rd_ptr_s);
            fifo_full_r <= ptr_full(wr_ptr_s, rd_ptr_s);
            overflow_r  <= overflow_r | (result_valid & full_s);
            led_r       <= state_onehot(state_s);
        end
    end

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign fifo_full = fifo_full_r;
    assign overflow  = overflow_r;
    assign ledState  = led_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: cycle-exact vector table plus a
// serial decoder feeding a scoreboard of expected words.
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic        tx, busy, fifo_full, overflow;
    logic [3:0]  led;

    int checks   = 0;
    int failures = 0;
    int bytes_rx = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic [15:0] data;
        int          n;
        logic [7:0]  exp;   // {tx, busy, fifo_full, overflow, ledState}
    } vec_t;
    vec_t vecs[$];

    result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .external_clk(clk),
        .reset(rst_n),
        .result_valid(valid),
        .ALU_result(data),
        .tx(tx),
        .busy(busy),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .ledState(led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] status();
        return {tx, busy, fifo_full, overflow, led};
    endfunction

    task automatic add_vec(input logic v, input logic [15:0] d, input int n,
                           input logic etx, input logic ebusy, input logic [3:0] eled);
        vec_t r;
        r.valid = v;
        r.data  = d;
        r.n     = n;
        r.exp   = {etx, ebusy, 1'b0, 1'b0, eled};
        vecs.push_back(r);
    endtask

    task automatic put(input logic [15:0] d, input logic expect_accept);
        valid = 1'b1;
        data  = d;
        if (expect_accept) exp_q.push_back(d);
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        #3 rst_n = 1'b1;
    endtask

    // Serial decoder: samples each bit one cycle into its period, rebuilds words.
    initial begin : decoder
        int          cnt;
        logic        in_frame;
        logic [7:0]  rx;
        logic [7:0]  hi;
        logic        have_hi;
        logic [15:0] w;
        logic [15:0] e;
        cnt = 0; in_frame = 1'b0; rx = 8'h00; hi = 8'h00; have_hi = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                have_hi  = 1'b0;
            end else if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame = 1'b1;
                    cnt      = 0;
                end
            end else begin
                cnt++;
                if ((cnt % CPB) == 1 && (cnt / CPB) >= 1 && (cnt / CPB) <= 8) begin
                    rx[(cnt / CPB) - 1] = tx;
                end else if (cnt == 9 * CPB + 1) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    in_frame = 1'b0;
                    bytes_rx++;
                    if (!have_hi) begin
                        hi      = rx;
                        have_hi = 1'b1;
                    end else begin
                        have_hi = 1'b0;
                        w       = {hi, rx};
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rx_word: got %h expected none", w);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rx_word", 32'(w), 32'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        logic [7:0]  hi_b;
        logic [7:0]  lo_b;
        logic [15:0] d;
        int          n;

        // Reset held with result_valid toggling: outputs stay at reset values.
        for (int i = 0; i < 50; i++) begin
            valid = i[0];
            data  = 16'($urandom);
            tick();
            chk("reset_hold", 32'(status()), 32'(8'b1000_0001));
        end
        valid = 1'b0;
        #3 rst_n = 1'b1;

        // Cycle-exact frame of 0xA55A.
        hi_b = 8'hA5;
        lo_b = 8'h5A;
        add_vec(1'b1, 16'hA55A, 1, 1'b1, 1'b1, 4'b0001);
        add_vec(1'b0, 16'h0000, CPB, 1'b0, 1'b1, 4'b0010);
        for (int b = 0; b < 8; b++) add_vec(1'b0, 16'h0000, CPB, hi_b[b], 1'b1, 4'b0100);
        add_vec(1'b0, 16'h0000, CPB, 1'b1, 1'b1, 4'b1000);
        add_vec(1'b0, 16'h0000, CPB, 1'b0, 1'b1, 4'b0010);
        for (int b = 0; b < 8; b++) add_vec(1'b0, 16'h0000, CPB, lo_b[b], 1'b1, 4'b0100);
        add_vec(1'b0, 16'h0000, CPB, 1'b1, 1'b1, 4'b1000);
        add_vec(1'b0, 16'h0000, 1, 1'b1, 1'b0, 4'b0001);
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                valid = vecs[i].valid;
                data  = vecs[i].data;
                if (vecs[i].valid) exp_q.push_back(vecs[i].data);
                tick();
                chk($sformatf("vec%0d", i), 32'(status()), 32'(vecs[i].exp));
            end
        end
        valid = 1'b0;
        wait_idle("drain_a55a", 200);

        // Six back-to-back writes: one in flight, four buffered, sixth dropped.
        bytes_rx = 0;
        for (int k = 1; k <= 6; k++) begin
            put(16'(k), k <= 5);
            if (k == 5) chk("full_no_ovf", 32'({fifo_full, overflow}), 32'(2'b10));
            if (k == 6) chk("drop_sixth", 32'({fifo_full, overflow}), 32'(2'b11));
        end
        wait_idle("drain_six", 1000);
        chk("bytes_six", 32'(bytes_rx), 32'd10);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Write on the same edge as a pop from a full FIFO: still dropped.
        do_reset();
        for (int k = 0; k < 5; k++) put(16'(16'h1111 * (k + 1)), 1'b1);
        repeat (77) tick();
        chk("idle_full", 32'({led, fifo_full}), 32'({4'b0001, 1'b1}));
        put(16'h6666, 1'b0);
        chk("drop_on_pop", 32'({fifo_full, overflow, led}), 32'({1'b0, 1'b1, 4'b0010}));
        wait_idle("drain_pop", 1000);

        // Asynchronous reset in the middle of the first data byte.
        do_reset();
        put(16'h0000, 1'b0);
        put(16'h1234, 1'b0);
        put(16'h5678, 1'b0);
        put(16'h9ABC, 1'b0);
        repeat (7) tick();
        chk("mid_data", 32'({tx, led}), 32'({1'b0, 4'b0100}));
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'(status()), 32'(8'b1000_0001));
        repeat (3) tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("post_reset_idle", 32'({tx, busy, fifo_full, led}), 32'(7'b100_0001));
        end

        // Random words with random gaps, never offered while full.
        for (int w = 0; w < 20; w++) begin
            repeat ($urandom_range(0, 30)) tick();
            n = 0;
            while (fifo_full && n < 300) begin
                tick();
                n++;
            end
            chk("space_wait", 32'(fifo_full), 32'd0);
            d = 16'($urandom);
            put(d, 1'b1);
        end
        wait_idle("drain_rand", 3000);
        chk("ovf_rand", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
